// File: rtl/alu_pipeline.sv
// alu_pipeline: two-stage ALU execution pipeline (operand collect/execute, writeback).
// Operands arrive from the PRF read response or the writeback forwarding bus; the
// result leaves over a valid/ready handshake towards the PRF writeback arbiter.
// Optional build macro ALU_PIPELINE_WB_SKID_EN turns the WB stage into a 2-entry
// FIFO whose accept is taken from registered state only.
module alu_pipeline #(
   parameter int unsigned LOG_PR_COUNT       = 6,
   parameter int unsigned LOG_PRF_BANK_COUNT = 2,
   localparam int unsigned PRF_BANK_COUNT    = 2 ** LOG_PRF_BANK_COUNT
) (
   input  logic                                 CLK,
   input  logic                                 nRST,
   input  logic                                 issue_valid,
   input  logic [3:0]                           issue_op,
   input  logic                                 issue_is_imm,
   input  logic [31:0]                          issue_imm,
   input  logic                                 issue_A_unneeded,
   input  logic                                 issue_A_forward,
   input  logic                                 issue_B_forward,
   input  logic [LOG_PRF_BANK_COUNT-1:0]        issue_A_bank,
   input  logic [LOG_PRF_BANK_COUNT-1:0]        issue_B_bank,
   input  logic [LOG_PR_COUNT-1:0]              issue_dest_PR,
   output logic                                 issue_ready,
   input  logic                                 reg_read_A_ack,
   input  logic                                 reg_read_B_ack,
   input  logic [31:0]                          reg_read_A_data,
   input  logic [31:0]                          reg_read_B_data,
   input  logic [PRF_BANK_COUNT-1:0][31:0]      forward_data_by_bank,
   output logic                                 WB_valid,
   output logic [31:0]                          WB_data,
   output logic [LOG_PR_COUNT-1:0]              WB_PR,
   input  logic                                 WB_ready
);

   // OC/EX stage state
   logic                          oc_valid_q, oc_valid_d;
   logic                          first_q, first_d;
   logic [3:0]                    op_q, op_d;
   logic [LOG_PR_COUNT-1:0]       dest_q, dest_d;
   logic                          a_coll_q, a_coll_d, b_coll_q, b_coll_d;
   logic [31:0]                   a_q, a_d, b_q, b_d;
   logic                          a_fwd_q, a_fwd_d, b_fwd_q, b_fwd_d;
   logic [LOG_PRF_BANK_COUNT-1:0] a_bank_q, a_bank_d, b_bank_q, b_bank_d;

   logic        a_take_fwd, a_take_rd, b_take_fwd, b_take_rd;
   logic        a_ready, b_ready, operands_ready;
   logic [31:0] a_val, b_val, result;
   logic        wb_accept, oc_advance, issue_fire;

   // Operand selection: a forwarded operand is only live in the first OC cycle,
   // a PRF operand is taken whenever its ack shows up while still uncollected.
   always_comb begin
      a_take_fwd = oc_valid_q & first_q & a_fwd_q & ~a_coll_q;
      a_take_rd  = oc_valid_q & ~a_fwd_q & ~a_coll_q & reg_read_A_ack;
      b_take_fwd = oc_valid_q & first_q & b_fwd_q & ~b_coll_q;
      b_take_rd  = oc_valid_q & ~b_fwd_q & ~b_coll_q & reg_read_B_ack;
      a_val = a_coll_q ? a_q : (a_take_fwd ? forward_data_by_bank[a_bank_q] : reg_read_A_data);
      b_val = b_coll_q ? b_q : (b_take_fwd ? forward_data_by_bank[b_bank_q] : reg_read_B_data);
      a_ready = a_coll_q | a_take_fwd | a_take_rd;
      b_ready = b_coll_q | b_take_fwd | b_take_rd;
      operands_ready = a_ready & b_ready;
      oc_advance  = oc_valid_q & operands_ready & wb_accept;
      issue_ready = ~oc_valid_q | oc_advance;
      issue_fire  = issue_valid & issue_ready;
   end

   // ALU function on the live/collected operands
   always_comb begin
      case (op_q)
         4'b0000: result = a_val + b_val;
         4'b1000: result = a_val - b_val;
         4'b0001: result = a_val << b_val[4:0];
         4'b0101: result = a_val >> b_val[4:0];
         4'b1101: result = 32'($signed(a_val) >>> b_val[4:0]);
         4'b0010: result = {31'b0, $signed(a_val) < $signed(b_val)};
         4'b0011: result = {31'b0, a_val < b_val};
         4'b0100: result = a_val ^ b_val;
         4'b0110: result = a_val | b_val;
         4'b0111: result = a_val & b_val;
         default: result = '0;
      endcase
   end

   // OC next state: load on issue, drain on advance, otherwise collect operands
   always_comb begin
      oc_valid_d = oc_valid_q;
      first_d    = 1'b0;
      op_d       = op_q;
      dest_d     = dest_q;
      a_coll_d   = a_coll_q;
      b_coll_d   = b_coll_q;
      a_d        = a_q;
      b_d        = b_q;
      a_fwd_d    = a_fwd_q;
      b_fwd_d    = b_fwd_q;
      a_bank_d   = a_bank_q;
      b_bank_d   = b_bank_q;
      if (issue_fire) begin
         oc_valid_d = 1'b1;
         first_d    = 1'b1;
         op_d       = issue_op;
         dest_d     = issue_dest_PR;
         a_coll_d   = issue_A_unneeded;
         a_d        = '0;
         b_coll_d   = issue_is_imm;
         b_d        = issue_is_imm ? issue_imm : '0;
         a_fwd_d    = issue_A_forward;
         b_fwd_d    = issue_B_forward;
         a_bank_d   = issue_A_bank;
         b_bank_d   = issue_B_bank;
      end else if (oc_advance) begin
         oc_valid_d = 1'b0;
      end else if (oc_valid_q) begin
         if (a_take_fwd | a_take_rd) begin
            a_coll_d = 1'b1;
            a_d      = a_val;
         end
         if (b_take_fwd | b_take_rd) begin
            b_coll_d = 1'b1;
            b_d      = b_val;
         end
      end
   end

   // OC registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         oc_valid_q <= 1'b0;
         first_q    <= 1'b0;
         op_q       <= '0;
         dest_q     <= '0;
         a_coll_q   <= 1'b0;
         b_coll_q   <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         a_fwd_q    <= 1'b0;
         b_fwd_q    <= 1'b0;
         a_bank_q   <= '0;
         b_bank_q   <= '0;
      end else begin
         oc_valid_q <= oc_valid_d;
         first_q    <= first_d;
         op_q       <= op_d;
         dest_q     <= dest_d;
         a_coll_q   <= a_coll_d;
         b_coll_q   <= b_coll_d;
         a_q        <= a_d;
         b_q        <= b_d;
         a_fwd_q    <= a_fwd_d;
         b_fwd_q    <= b_fwd_d;
         a_bank_q   <= a_bank_d;
         b_bank_q   <= b_bank_d;
      end
   end

`ifdef ALU_PIPELINE_WB_SKID_EN
   logic [1:0]              cnt_q;
   logic                    head_q;
   logic                    tail;
   logic                    deq;
   logic [31:0]             fd_q [2];
   logic [LOG_PR_COUNT-1:0] fp_q [2];

   // Accept depends only on occupancy, so WB_ready never reaches issue_ready
   always_comb begin
      wb_accept = (cnt_q != 2'd2);
      deq       = (cnt_q != 2'd0) & WB_ready;
      tail      = head_q ^ cnt_q[0];
      WB_valid  = (cnt_q != 2'd0);
      WB_data   = fd_q[head_q];
      WB_PR     = fp_q[head_q];
   end

   // Two-entry WB FIFO; simultaneous enqueue and dequeue keep the count
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt_q  <= '0;
         head_q <= 1'b0;
         for (int unsigned i = 0; i < 2; i++) begin
            fd_q[i] <= '0;
            fp_q[i] <= '0;
         end
      end else begin
         if (oc_advance) begin
            fd_q[tail] <= result;
            fp_q[tail] <= dest_q;
         end
         if (deq) head_q <= ~head_q;
         cnt_q <= cnt_q + {1'b0, oc_advance} - {1'b0, deq};
      end
   end
`else
   logic                    wb_valid_q;
   logic [31:0]             wb_data_q;
   logic [LOG_PR_COUNT-1:0] wb_pr_q;

   // Single WB register; accept frees up in the same cycle as the handshake
   always_comb begin
      wb_accept = ~wb_valid_q | WB_ready;
      WB_valid  = wb_valid_q;
      WB_data   = wb_data_q;
      WB_PR     = wb_pr_q;
   end

   // WB register holds its contents while stalled
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_pr_q    <= '0;
      end else if (oc_advance) begin
         wb_valid_q <= 1'b1;
         wb_data_q  <= result;
         wb_pr_q    <= dest_q;
      end else if (WB_ready) begin
         wb_valid_q <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_pipeline.sv
// tb_alu_pipeline: directed self-checking bench for alu_pipeline (default build).
module tb_alu_pipeline;

   logic              CLK = 1'b0;
   logic              nRST;
   logic              issue_valid;
   logic [3:0]        issue_op;
   logic              issue_is_imm;
   logic [31:0]       issue_imm;
   logic              issue_A_unneeded;
   logic              issue_A_forward;
   logic              issue_B_forward;
   logic [1:0]        issue_A_bank;
   logic [1:0]        issue_B_bank;
   logic [5:0]        issue_dest_PR;
   logic              issue_ready;
   logic              reg_read_A_ack;
   logic              reg_read_B_ack;
   logic [31:0]       reg_read_A_data;
   logic [31:0]       reg_read_B_data;
   logic [3:0][31:0]  forward_data_by_bank;
   logic              WB_valid;
   logic [31:0]       WB_data;
   logic [5:0]        WB_PR;
   logic              WB_ready;

   int total = 0;
   int bad   = 0;

   alu_pipeline #(.LOG_PR_COUNT(6), .LOG_PRF_BANK_COUNT(2)) dut (
      .CLK(CLK), .nRST(nRST),
      .issue_valid(issue_valid), .issue_op(issue_op), .issue_is_imm(issue_is_imm),
      .issue_imm(issue_imm), .issue_A_unneeded(issue_A_unneeded),
      .issue_A_forward(issue_A_forward), .issue_B_forward(issue_B_forward),
      .issue_A_bank(issue_A_bank), .issue_B_bank(issue_B_bank),
      .issue_dest_PR(issue_dest_PR), .issue_ready(issue_ready),
      .reg_read_A_ack(reg_read_A_ack), .reg_read_B_ack(reg_read_B_ack),
      .reg_read_A_data(reg_read_A_data), .reg_read_B_data(reg_read_B_data),
      .forward_data_by_bank(forward_data_by_bank),
      .WB_valid(WB_valid), .WB_data(WB_data), .WB_PR(WB_PR), .WB_ready(WB_ready)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid      = 1'b0;
      issue_op         = 4'h0;
      issue_is_imm     = 1'b0;
      issue_imm        = '0;
      issue_A_unneeded = 1'b0;
      issue_A_forward  = 1'b0;
      issue_B_forward  = 1'b0;
      issue_A_bank     = '0;
      issue_B_bank     = '0;
      issue_dest_PR    = '0;
      reg_read_A_ack   = 1'b0;
      reg_read_B_ack   = 1'b0;
      reg_read_A_data  = '0;
      reg_read_B_data  = '0;
      forward_data_by_bank = '0;
      WB_ready         = 1'b1;
   endtask

   // op with A = 0 and B = immediate, so the result is op(0, imm)
   task automatic issue_const(input logic [31:0] imm, input logic [5:0] dest);
      issue_valid      = 1'b1;
      issue_op         = 4'b0000;
      issue_is_imm     = 1'b1;
      issue_imm        = imm;
      issue_A_unneeded = 1'b1;
      issue_A_forward  = 1'b0;
      issue_B_forward  = 1'b0;
      issue_dest_PR    = dest;
   endtask

   // op, A from PRF, B immediate, expected result
   logic [3:0]  t_op  [11] = '{4'b0000, 4'b1000, 4'b0001, 4'b0101, 4'b0010, 4'b0011,
                               4'b0100, 4'b0110, 4'b0111, 4'b1111, 4'b1001};
   logic [31:0] t_a   [11] = '{32'hFFFFFFFF, 32'h5, 32'h1, 32'h80000000, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                               32'h12345678, 32'h5};
   logic [31:0] t_b   [11] = '{32'h2, 32'h7, 32'h24, 32'd31, 32'h1, 32'h1, 32'hFF00FF00,
                               32'h0F0F0000, 32'hFF00FF00, 32'h1, 32'h1};
   logic [31:0] t_exp [11] = '{32'h1, 32'hFFFFFFFE, 32'h10, 32'h1, 32'h1, 32'h0,
                               32'h0FF00FF0, 32'hFFFFF0F0, 32'hF000F000, 32'h0, 32'h0};

   initial begin
      idle_inputs();
      nRST = 1'b0;
      #1;
      chk("rst_wb_valid_async", 32'(WB_valid), 32'h0);
      step();
      step();
      nRST = 1'b1;

      // reset then idle
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_issue_ready", 32'(issue_ready), 32'h1);
         chk("idle_wb_valid",    32'(WB_valid),    32'h0);
         chk("idle_wb_data",     WB_data,          32'h0);
         chk("idle_wb_pr",       32'(WB_PR),       32'h0);
      end

      // ADD: A from PRF (0x5) at t+1, B imm 0x10
      step();
      issue_valid = 1'b1; issue_op = 4'b0000; issue_is_imm = 1'b1; issue_imm = 32'h10;
      issue_dest_PR = 6'h07;
      #1 chk("add_issue_ready_t", 32'(issue_ready), 32'h1);
      step();
      issue_valid = 1'b0; reg_read_A_ack = 1'b1; reg_read_A_data = 32'h5;
      #1 chk("add_issue_ready_t1", 32'(issue_ready), 32'h1);
      chk("add_wb_valid_t1", 32'(WB_valid), 32'h0);
      step();
      reg_read_A_ack = 1'b0; reg_read_A_data = 32'hDEADBEEF;
      chk("add_wb_valid", 32'(WB_valid), 32'h1);
      chk("add_wb_data",  WB_data,       32'h15);
      chk("add_wb_pr",    32'(WB_PR),    32'h07);
      step();
      chk("add_wb_drain", 32'(WB_valid), 32'h0);

      // SUB: both operands forwarded, forward data changes afterwards
      issue_valid = 1'b1; issue_op = 4'b1000; issue_is_imm = 1'b0;
      issue_A_forward = 1'b1; issue_A_bank = 2'd2;
      issue_B_forward = 1'b1; issue_B_bank = 2'd1; issue_dest_PR = 6'h09;
      step();
      idle_inputs();
      forward_data_by_bank[2] = 32'h3;
      forward_data_by_bank[1] = 32'h5;
      reg_read_A_ack = 1'b1; reg_read_A_data = 32'h777;
      step();
      reg_read_A_ack = 1'b0;
      forward_data_by_bank[2] = 32'hAAAA;
      forward_data_by_bank[1] = 32'h1;
      chk("sub_wb_valid", 32'(WB_valid), 32'h1);
      chk("sub_wb_data",  WB_data,       32'hFFFFFFFE);
      chk("sub_wb_pr",    32'(WB_PR),    32'h09);
      forward_data_by_bank = '0;

      // SRA: A ack at t+1, B ack at t+3; late A ack is ignored
      step();
      issue_valid = 1'b1; issue_op = 4'b1101; issue_is_imm = 1'b0; issue_dest_PR = 6'h11;
      step();
      issue_valid = 1'b0;
      reg_read_A_ack = 1'b1; reg_read_A_data = 32'h80000000;
      #1 chk("sra_issue_ready_t1", 32'(issue_ready), 32'h0);
      step();
      reg_read_A_data = 32'h12345678;
      #1 chk("sra_issue_ready_t2", 32'(issue_ready), 32'h0);
      step();
      reg_read_A_ack = 1'b0;
      reg_read_B_ack = 1'b1; reg_read_B_data = 32'h4;
      #1 chk("sra_issue_ready_t3", 32'(issue_ready), 32'h1);
      chk("sra_wb_valid_t3", 32'(WB_valid), 32'h0);
      step();
      reg_read_B_ack = 1'b0;
      chk("sra_wb_valid", 32'(WB_valid), 32'h1);
      chk("sra_wb_data",  WB_data,       32'hF8000000);
      chk("sra_wb_pr",    32'(WB_PR),    32'h11);

      // back-to-back ADDs with a 2-cycle WB stall
      step();
      idle_inputs();
      issue_const(32'h101, 6'h01);
      step();
      issue_const(32'h202, 6'h02);
      #1 chk("b2b_ready_c1", 32'(issue_ready), 32'h1);
      step();
      issue_const(32'h303, 6'h03);
      WB_ready = 1'b0;
      #1 chk("b2b_ready_c2", 32'(issue_ready), 32'h0);
      chk("b2b_data_c2", WB_data,    32'h101);
      chk("b2b_pr_c2",   32'(WB_PR), 32'h01);
      step();
      chk("b2b_valid_c3", 32'(WB_valid), 32'h1);
      chk("b2b_data_c3",  WB_data,       32'h101);
      chk("b2b_pr_c3",    32'(WB_PR),    32'h01);
      chk("b2b_ready_c3", 32'(issue_ready), 32'h0);
      step();
      WB_ready = 1'b1;
      #1 chk("b2b_data_c4", WB_data, 32'h101);
      chk("b2b_ready_c4", 32'(issue_ready), 32'h1);
      step();
      issue_valid = 1'b0;
      chk("b2b_valid_c5", 32'(WB_valid), 32'h1);
      chk("b2b_data_c5",  WB_data,       32'h202);
      chk("b2b_pr_c5",    32'(WB_PR),    32'h02);
      step();
      chk("b2b_valid_c6", 32'(WB_valid), 32'h1);
      chk("b2b_data_c6",  WB_data,       32'h303);
      chk("b2b_pr_c6",    32'(WB_PR),    32'h03);
      step();
      chk("b2b_valid_c7", 32'(WB_valid), 32'h0);

      // op table at full throughput: issue k in cycle k, A ack in k+1, WB in k+2
      for (int k = 0; k < 13; k++) begin
         step();
         if (k < 11) begin
            issue_valid = 1'b1; issue_op = t_op[k]; issue_is_imm = 1'b1; issue_imm = t_b[k];
            issue_A_unneeded = 1'b0; issue_dest_PR = 6'(32 + k);
         end else begin
            issue_valid = 1'b0;
         end
         if (k >= 1 && k <= 11) begin
            reg_read_A_ack = 1'b1; reg_read_A_data = t_a[k-1];
         end else begin
            reg_read_A_ack = 1'b0;
         end
         #1;
         if (k < 11) chk($sformatf("tbl_ready_%0d", k), 32'(issue_ready), 32'h1);
         if (k >= 2) begin
            chk($sformatf("tbl_valid_%0d", k-2), 32'(WB_valid), 32'h1);
            chk($sformatf("tbl_data_%0d", k-2),  WB_data,       t_exp[k-2]);
            chk($sformatf("tbl_pr_%0d", k-2),    32'(WB_PR),    32'(32 + k - 2));
         end
      end
      step();
      idle_inputs();
      #1 chk("tbl_drain", 32'(WB_valid), 32'h0);

      // reset while OC and WB both hold ops
      step();
      issue_const(32'h55, 6'h05);
      step();
      issue_const(32'h66, 6'h06);
      step();
      issue_valid = 1'b0;
      WB_ready = 1'b0;
      #1 chk("mid_wb_valid", 32'(WB_valid), 32'h1);
      chk("mid_wb_data", WB_data, 32'h55);
      chk("mid_issue_ready", 32'(issue_ready), 32'h0);
      nRST = 1'b0;
      #1 chk("mid_rst_wb_valid", 32'(WB_valid), 32'h0);
      chk("mid_rst_wb_data", WB_data, 32'h0);
      chk("mid_rst_wb_pr", 32'(WB_PR), 32'h0);
      chk("mid_rst_issue_ready", 32'(issue_ready), 32'h1);
      step();
      nRST = 1'b1;
      WB_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_wb_valid", 32'(WB_valid), 32'h0);
         chk("post_rst_issue_ready", 32'(issue_ready), 32'h1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
